// File: rtl/mac_unit_v3.sv
// Multi-lane multiply-accumulate unit with a shared weight shift chain.
// Each lane accumulates a 1..W_D step dot product and hands it off over a valid/ready port.
module mac_unit_v3 #(
    parameter int I_W    = 8,
    parameter int W_W    = 8,
    parameter int LANES  = 2,
    parameter int W_D    = 4,
    parameter int RES_W  = 32,
    parameter int SAT_EN = 1,
    localparam int W_D_LOG2 = $clog2(W_D)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [W_D_LOG2-1:0]      cfg_len,
    input  logic                     cfg_signed,
    input  logic [W_W-1:0]           W_in,
    input  logic                     W_en,
    output logic [W_W-1:0]           W_out,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic [LANES*I_W-1:0]     i_data,
    input  logic [LANES*RES_W-1:0]   Res_in,
    input  logic                     Res_in_en,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [LANES*RES_W-1:0]   o_data,
    output logic [LANES-1:0]         o_ovf,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                state, state_nxt;
    logic [W_D_LOG2-1:0]   step, len_q;
    logic                  signed_q;
    logic [W_W-1:0]        w [W_D];
    logic [RES_W-1:0]      acc [LANES];
    logic [RES_W-1:0]      acc_nxt [LANES];
    logic [LANES-1:0]      ovf_q, ovf_add;
    logic                  take, signed_sel;
    logic [W_W-1:0]        w_sel;

    assign take       = i_valid && i_ready;
    assign signed_sel = (state == IDLE) ? cfg_signed : signed_q;
    assign w_sel      = (state == IDLE) ? w[0] : w[step];

    // i_ready depends on registered state only (plus reset, which forces it low).
    assign i_ready = !reset && (state != OUT);
    assign o_valid = (state == OUT);
    assign busy    = (state != IDLE);
    assign W_out   = w[0];
    assign o_ovf   = ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (take) state_nxt = (cfg_len == '0) ? OUT : ACC;
            ACC:  if (take && step == len_q) state_nxt = OUT;
            OUT:  if (o_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-lane product and add in RES_W+1 bits; the extra bit exposes carry or sign overflow.
    always_comb begin : lane_math
        logic [I_W-1:0]            a;
        logic signed [I_W:0]       a_ext;
        logic signed [W_W:0]       w_ext;
        logic signed [I_W+W_W+1:0] prod;
        logic [RES_W-1:0]          base;
        logic signed [RES_W:0]     base_ext, sum;
        for (int l = 0; l < LANES; l++) begin
            a        = i_data[l*I_W +: I_W];
            a_ext    = {signed_sel & a[I_W-1], a};
            w_ext    = {signed_sel & w_sel[W_W-1], w_sel};
            prod     = a_ext * w_ext;
            base     = (state == IDLE) ? (Res_in_en ? Res_in[l*RES_W +: RES_W] : '0) : acc[l];
            base_ext = {signed_sel & base[RES_W-1], base};
            sum      = base_ext + (RES_W+1)'(prod);
            ovf_add[l] = signed_sel ? (sum[RES_W] ^ sum[RES_W-1]) : sum[RES_W];
            acc_nxt[l] = sum[RES_W-1:0];
            if (ovf_add[l] && SAT_EN != 0) begin
                if (!signed_sel)      acc_nxt[l] = '1;
                else if (sum[RES_W])  acc_nxt[l] = {1'b1, {(RES_W-1){1'b0}}};
                else                  acc_nxt[l] = {1'b0, {(RES_W-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step     <= '0;
            len_q    <= '0;
            signed_q <= 1'b0;
            ovf_q    <= '0;
            // NOTE: the weight chain and accumulators are plain flops with defined reset values, so they are cleared here.
            for (int j = 0; j < W_D; j++)   w[j]   <= '0;
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
        end else begin
            if (W_en && state == IDLE) begin
                for (int j = 0; j < W_D-1; j++) w[j] <= w[j+1];
                w[W_D-1] <= W_in;
            end
            if (take) begin
                for (int l = 0; l < LANES; l++) acc[l] <= acc_nxt[l];
                if (state == IDLE) begin
                    len_q    <= cfg_len;
                    signed_q <= cfg_signed;
                    step     <= W_D_LOG2'(1);
                    ovf_q    <= ovf_add;
                end else begin
                    step  <= step + 1'b1;
                    ovf_q <= ovf_q | ovf_add;
                end
            end
        end
    end

    always_comb begin
        o_data = '0;
        for (int l = 0; l < LANES; l++) o_data[l*RES_W +: RES_W] = acc[l];
    end

endmodule

// File: tb/tb_mac_unit_v3.sv
// Directed bench for mac_unit_v3: hand-computed dot products, saturation, backpressure and reset.
module tb_mac_unit_v3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cfg_len;
    logic        cfg_signed;
    logic [7:0]  W_in;
    logic        W_en;
    logic [7:0]  W_out;
    logic        i_valid;
    logic        i_ready;
    logic [15:0] i_data;
    logic [63:0] Res_in;
    logic        Res_in_en;
    logic        o_valid;
    logic        o_ready;
    logic [63:0] o_data;
    logic [1:0]  o_ovf;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mac_unit_v3 dut (
        .clk(clk), .reset(reset), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
        .W_in(W_in), .W_en(W_en), .W_out(W_out),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .Res_in(Res_in), .Res_in_en(Res_in_en),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_ovf(o_ovf),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic [7:0] x);
        W_en = 1'b1;
        W_in = x;
        tick();
        W_en = 1'b0;
    endtask

    task automatic load4(input logic [7:0] x0, x1, x2, x3);
        load_w(x0); load_w(x1); load_w(x2); load_w(x3);
    endtask

    task automatic beat(input string tag, input logic [7:0] a0, input logic [7:0] a1);
        check({tag, " i_ready"}, 64'(i_ready), 64'd1);
        i_valid = 1'b1;
        i_data  = {a1, a0};
        tick();
        i_valid = 1'b0;
    endtask

    task automatic result(input string tag, input logic [63:0] exp_data, input logic [1:0] exp_ovf);
        check({tag, " o_valid"}, 64'(o_valid), 64'd1);
        check({tag, " o_data"},  o_data, exp_data);
        check({tag, " o_ovf"},   64'(o_ovf), 64'(exp_ovf));
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
        check({tag, " idle busy"}, 64'(busy), 64'd0);
        check({tag, " idle o_valid"}, 64'(o_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1; cfg_len = '0; cfg_signed = 1'b0; W_in = '0; W_en = 1'b0;
        i_valid = 1'b0; i_data = '0; Res_in = '0; Res_in_en = 1'b0; o_ready = 1'b0;
        tick(); tick();
        check("rst i_ready", 64'(i_ready), 64'd0);
        check("rst o_valid", 64'(o_valid), 64'd0);
        check("rst busy",    64'(busy),    64'd0);
        check("rst W_out",   64'(W_out),   64'd0);
        check("rst o_data",  o_data,       64'd0);
        check("rst o_ovf",   64'(o_ovf),   64'd0);
        reset = 1'b0;
        #1;
        check("post-rst i_ready", 64'(i_ready), 64'd1);

        // 4-step signed dot product: lane0 1*(1+2+3+4)=10, lane1 -1*10=-10.
        load4(8'd1, 8'd2, 8'd3, 8'd4);
        check("chain W_out", 64'(W_out), 64'd1);
        cfg_len = 2'd3; cfg_signed = 1'b1; Res_in_en = 1'b0;
        beat("t1 b0", 8'd1, 8'hFF);
        beat("t1 b1", 8'd1, 8'hFF);
        beat("t1 b2", 8'd1, 8'hFF);
        check("t1 pre o_valid", 64'(o_valid), 64'd0);
        beat("t1 b3", 8'd1, 8'hFF);
        check("t1 i_ready in OUT", 64'(i_ready), 64'd0);
        result("t1", {32'hFFFF_FFF6, 32'd10}, 2'b00);

        // Single step from base: 100+5*1=105, 7+2*1=9; then hold OUT under backpressure.
        cfg_len = 2'd0; Res_in_en = 1'b1; Res_in = {32'd7, 32'd100};
        beat("t2 b0", 8'd5, 8'd2);
        for (int k = 0; k < 5; k++) begin
            W_en = 1'b1; W_in = 8'd9;
            check("bp o_data",  o_data, {32'd9, 32'd105});
            check("bp i_ready", 64'(i_ready), 64'd0);
            check("bp o_valid", 64'(o_valid), 64'd1);
            tick();
            W_en = 1'b0;
            check("bp W_out", 64'(W_out), 64'd1);
        end
        result("t2", {32'd9, 32'd105}, 2'b00);
        check("t2 W_out after", 64'(W_out), 64'd1);

        // Signed saturation, then keep accumulating from the clamp with a sticky flag.
        // lane0: 0x7FFFFFF0+127*127 -> 0x7FFFFFFF, +1*(-1) -> 0x7FFFFFFE.
        // lane1: 0x80000010+(-127*127) -> 0x80000000, +0 -> 0x80000000.
        load4(8'd127, 8'hFF, 8'd0, 8'd0);
        cfg_len = 2'd1; cfg_signed = 1'b1; Res_in_en = 1'b1;
        Res_in = {32'h8000_0010, 32'h7FFF_FFF0};
        beat("sat b0", 8'd127, 8'h81);
        beat("sat b1", 8'd1, 8'd0);
        result("sat", {32'h8000_0000, 32'h7FFF_FFFE}, 2'b11);

        // Unsigned: 0xFFFFFF00+255*255 carries out -> all ones; lane1 5+255=260.
        load4(8'd255, 8'd0, 8'd0, 8'd0);
        cfg_len = 2'd0; cfg_signed = 1'b0;
        Res_in = {32'd5, 32'hFFFF_FF00};
        beat("usat b0", 8'd255, 8'd1);
        result("usat", {32'd260, 32'hFFFF_FFFF}, 2'b01);

        // Gapped beats with cfg/Res_in changes after the first beat: 2*10=20, 3*10=30.
        load4(8'd1, 8'd2, 8'd3, 8'd4);
        cfg_len = 2'd3; cfg_signed = 1'b1; Res_in_en = 1'b0;
        beat("gap b0", 8'd2, 8'd3);
        cfg_len = 2'd0; Res_in_en = 1'b1; Res_in = {32'd1000, 32'd1000};
        tick(); tick();
        check("gap hold busy", 64'(busy), 64'd1);
        beat("gap b1", 8'd2, 8'd3);
        beat("gap b2", 8'd2, 8'd3);
        check("gap pre o_valid", 64'(o_valid), 64'd0);
        beat("gap b3", 8'd2, 8'd3);
        result("gap", {32'd30, 32'd20}, 2'b00);

        // Reset asserted during the second ACC beat.
        cfg_len = 2'd3; Res_in_en = 1'b0;
        beat("rst b0", 8'd1, 8'd1);
        i_valid = 1'b1; i_data = {8'd1, 8'd1};
        #2 reset = 1'b1;
        #1;
        check("mid-rst o_valid", 64'(o_valid), 64'd0);
        check("mid-rst busy",    64'(busy),    64'd0);
        check("mid-rst W_out",   64'(W_out),   64'd0);
        check("mid-rst i_ready", 64'(i_ready), 64'd0);
        check("mid-rst o_data",  o_data,       64'd0);
        tick();
        i_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("after-rst busy", 64'(busy), 64'd0);

        // Fresh run after reset: 3*10=30, 1*10=10.
        load4(8'd1, 8'd2, 8'd3, 8'd4);
        beat("fresh b0", 8'd3, 8'd1);
        beat("fresh b1", 8'd3, 8'd1);
        beat("fresh b2", 8'd3, 8'd1);
        beat("fresh b3", 8'd3, 8'd1);
        result("fresh", {32'd10, 32'd30}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
